issue_ctrl: RTL

ISSUE_CTRL -- requirements
Module: issue_ctrl

---
 rtl/issue_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/issue_ctrl.sv
// rtl/issue_ctrl.sv - one-entry issue holding register with register/memory scoreboard.
// Optional stall counter enabled by defining ISSUE_CTRL_PERF_EN.
module issue_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic        in_uses_rs2,
  input  logic        in_reg_write,
  input  logic        in_load_store,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic        out_reg_write,
  output logic        out_load_store,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        mem_done,
  input  logic        flush,
  output logic [31:0] busy_vec,
  output logic        mem_busy,
  output logic [15:0] stall_cycles
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        held_uses_rs2;
  logic [31:0] wb_clr;
  logic [31:0] issue_set;
  logic [31:0] eff_busy;
  logic [31:0] busy_nxt;
  logic        eff_mem_busy;
  logic        mem_busy_nxt;
  logic        hazard;
  logic        issue;
  logic        capture;

  // Writeback and mem_done are bypassed so a waiting entry can issue in the retire cycle.
  always_comb begin
    wb_clr       = wb_valid ? (32'h1 << wb_rd) : 32'h0;
    eff_busy     = busy_vec & ~wb_clr;
    eff_mem_busy = mem_busy & ~mem_done;
    hazard       = eff_busy[out_rs1]
                 | (held_uses_rs2 & eff_busy[out_rs2])
                 | (out_reg_write & eff_busy[out_rd])
                 | (out_load_store & eff_mem_busy);
  end

  always_comb begin
    out_valid = (state == FULL) & ~hazard & ~flush;
    issue     = out_valid & out_ready;
    in_ready  = rst_n & ~flush & ((state == EMPTY) | issue);
    capture   = in_valid & in_ready;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else if (capture) begin
      state_nxt = FULL;
    end else if (issue) begin
      state_nxt = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_rd         <= 5'd0;
      out_rs1        <= 5'd0;
      out_rs2        <= 5'd0;
      held_uses_rs2  <= 1'b0;
      out_reg_write  <= 1'b0;
      out_load_store <= 1'b0;
    end else if (capture) begin
      out_rd         <= in_rd;
      out_rs1        <= in_rs1;
      out_rs2        <= in_rs2;
      held_uses_rs2  <= in_uses_rs2;
      out_reg_write  <= in_reg_write;
      out_load_store <= in_load_store;
    end
  end

  // Set is applied after clear so an issue colliding with a retire keeps the bit; x0 is never tracked.
  always_comb begin
    issue_set    = (issue & out_reg_write & (out_rd != 5'd0)) ? (32'h1 << out_rd) : 32'h0;
    busy_nxt     = ((busy_vec & ~wb_clr) | issue_set) & 32'hFFFF_FFFE;
    mem_busy_nxt = eff_mem_busy | (issue & out_load_store);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_vec <= 32'h0;
      mem_busy <= 1'b0;
    end else begin
      busy_vec <= busy_nxt;
      mem_busy <= mem_busy_nxt;
    end
  end

`ifdef ISSUE_CTRL_PERF_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 16'h0000;
    end else if ((state == FULL) && !flush && !issue && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 16'h0000;
`endif

endmodule
